// File: rtl/drop_scheduler_pkg.sv
// Shared definitions for the drop scheduler: phase encodings and default tick constants.
package drop_scheduler_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FALL  = 3'd1,
    PH_LOCK  = 3'd2,
    PH_CLEAR = 3'd3,
    PH_OVER  = 3'd4
  } phase_t;

  localparam int DEF_BASE_TICKS      = 100000000;
  localparam int DEF_LEVEL_STEP      = 6000000;
  localparam int DEF_SOFT_TICKS      = 5000000;
  localparam int DEF_LOCK_TICKS      = 50000000;
  localparam int DEF_MAX_LOCK_RESETS = 15;
  localparam int DEF_CNT_W           = 27;

  // Width needed to hold 0..max_resets, never narrower than one bit.
  function automatic int reset_count_width(input int max_resets);
    return (max_resets < 1) ? 1 : $clog2(max_resets + 1);
  endfunction

endpackage

// File: rtl/drop_scheduler_interval.sv
// Shared interval counter: counts while enabled, flags when the count reaches limit-1.
module interval_timer
  import drop_scheduler_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // Count register: clear wins over enable, otherwise the count holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // A >= test so that a limit that shrinks mid-interval fires on the next cycle.
  assign hit = (count >= (limit - CNT_W'(1)));

endmodule

// File: rtl/drop_scheduler.sv
// Gravity and lock-delay sequencer: emits drop ticks from the level, runs the lock window, waits on row clears.
module drop_scheduler
  import drop_scheduler_pkg::*;
#(
  parameter int BASE_TICKS      = DEF_BASE_TICKS,
  parameter int LEVEL_STEP      = DEF_LEVEL_STEP,
  parameter int SOFT_TICKS      = DEF_SOFT_TICKS,
  parameter int LOCK_TICKS      = DEF_LOCK_TICKS,
  parameter int MAX_LOCK_RESETS = DEF_MAX_LOCK_RESETS,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       soft_drop,
  input  logic [3:0] level,
  input  logic       landed,
  input  logic       moved,
  input  logic       clear_done,
  input  logic       top_out,
  output logic       drop,
  output logic       lock,
  output logic [2:0] phase,
  output logic       paused
);

  localparam int RC_W   = reset_count_width(MAX_LOCK_RESETS);
  localparam int WIDE_W = CNT_W + 4;

  localparam logic [WIDE_W-1:0] BASE_WIDE  = WIDE_W'(BASE_TICKS);
  localparam logic [WIDE_W-1:0] STEP_WIDE  = WIDE_W'(LEVEL_STEP);
  localparam logic [CNT_W-1:0]  SOFT_LIMIT = CNT_W'(SOFT_TICKS);
  localparam logic [CNT_W-1:0]  LOCK_LIMIT = CNT_W'(LOCK_TICKS);
  localparam logic [RC_W-1:0]   RC_MAX     = RC_W'(MAX_LOCK_RESETS);

  phase_t state, state_next;

  logic [RC_W-1:0]   rst_cnt, rst_cnt_next;
  logic              drop_next, lock_next;
  logic              tmr_clear, tmr_enable, tmr_hit;
  logic [CNT_W-1:0]  tmr_limit;
  logic [WIDE_W-1:0] wide_interval;
  logic [CNT_W-1:0]  drop_interval;
  logic              in_play, frozen;

  // Level interval is formed with four bits of headroom and then truncated to the counter width.
  assign wide_interval = BASE_WIDE - STEP_WIDE * {{CNT_W{1'b0}}, level};
  assign drop_interval = soft_drop ? SOFT_LIMIT : CNT_W'(wide_interval);

  assign in_play = (state == PH_FALL) || (state == PH_LOCK) || (state == PH_CLEAR);
  assign frozen  = pause && in_play;
  assign paused  = frozen;
  assign phase   = state;

  interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .limit  (tmr_limit),
    .hit    (tmr_hit)
  );

  // State, reset count and the registered drop/lock pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PH_IDLE;
      rst_cnt <= '0;
      drop    <= 1'b0;
      lock    <= 1'b0;
    end else begin
      state   <= state_next;
      rst_cnt <= rst_cnt_next;
      drop    <= drop_next;
      lock    <= lock_next;
    end
  end

  // Next state, timer control and pulse decisions; pause freezes everything, then top_out ends play.
  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    drop_next    = 1'b0;
    lock_next    = 1'b0;
    tmr_clear    = 1'b0;
    tmr_enable   = 1'b0;
    tmr_limit    = drop_interval;
    unique case (state)
      PH_IDLE, PH_OVER: begin
        tmr_clear = 1'b1;
        if (start) begin
          state_next   = PH_FALL;
          rst_cnt_next = '0;
        end
      end
      PH_FALL: begin
        if (frozen) begin
          state_next = state;
        end else if (top_out) begin
          state_next = PH_OVER;
          tmr_clear  = 1'b1;
        end else if (landed) begin
          state_next = PH_LOCK;
          tmr_clear  = 1'b1;
        end else if (tmr_hit) begin
          drop_next = 1'b1;
          tmr_clear = 1'b1;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      PH_LOCK: begin
        tmr_limit = LOCK_LIMIT;
        if (frozen) begin
          state_next = state;
        end else if (top_out) begin
          state_next = PH_OVER;
          tmr_clear  = 1'b1;
        end else if (!landed) begin
          state_next = PH_FALL;
          tmr_clear  = 1'b1;
        end else if (moved && (rst_cnt < RC_MAX)) begin
          tmr_clear    = 1'b1;
          rst_cnt_next = rst_cnt + RC_W'(1);
        end else if (tmr_hit) begin
          lock_next    = 1'b1;
          state_next   = PH_CLEAR;
          tmr_clear    = 1'b1;
          rst_cnt_next = '0;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      PH_CLEAR: begin
        if (frozen) begin
          state_next = state;
        end else if (top_out) begin
          state_next = PH_OVER;
          tmr_clear  = 1'b1;
        end else begin
          tmr_clear = 1'b1;
          if (clear_done) begin
            state_next = PH_FALL;
          end
        end
      end
      default: begin
        state_next = PH_IDLE;
        tmr_clear  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_drop_scheduler.sv
// Self-checking bench for drop_scheduler: directed scenarios followed by random traffic against a rule-level model.
module tb_drop_scheduler;

  localparam int BASE  = 100;
  localparam int STEP  = 6;
  localparam int SOFT  = 5;
  localparam int LOCKT = 20;
  localparam int MAXR  = 2;
  localparam int CW    = 27;

  localparam int M_IDLE  = 0;
  localparam int M_FALL  = 1;
  localparam int M_LOCK  = 2;
  localparam int M_CLEAR = 3;
  localparam int M_OVER  = 4;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       start      = 1'b0;
  logic       pause      = 1'b0;
  logic       soft_drop  = 1'b0;
  logic [3:0] level      = 4'd0;
  logic       landed     = 1'b0;
  logic       moved      = 1'b0;
  logic       clear_done = 1'b0;
  logic       top_out    = 1'b0;
  logic       drop, lock, paused;
  logic [2:0] phase;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: game phase, cycles spent in the current window, lock restarts used.
  int mPhase;
  int mElapsed;
  int mResets;
  bit mDrop;
  bit mLock;

  drop_scheduler #(
    .BASE_TICKS      (BASE),
    .LEVEL_STEP      (STEP),
    .SOFT_TICKS      (SOFT),
    .LOCK_TICKS      (LOCKT),
    .MAX_LOCK_RESETS (MAXR),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .soft_drop  (soft_drop),
    .level      (level),
    .landed     (landed),
    .moved      (moved),
    .clear_done (clear_done),
    .top_out    (top_out),
    .drop       (drop),
    .lock       (lock),
    .phase      (phase),
    .paused     (paused)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case something stalls the directed sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int modelInterval();
    if (soft_drop) return SOFT;
    return (BASE - int'(level) * STEP) & ((1 << CW) - 1);
  endfunction

  function automatic bit modelInPlay();
    return (mPhase == M_FALL) || (mPhase == M_LOCK) || (mPhase == M_CLEAR);
  endfunction

  task automatic modelReset();
    mPhase   = M_IDLE;
    mElapsed = 0;
    mResets  = 0;
    mDrop    = 1'b0;
    mLock    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs that are about to be sampled.
  task automatic modelStep();
    mDrop = 1'b0;
    mLock = 1'b0;
    if (pause && modelInPlay()) return;
    if (top_out && modelInPlay()) begin
      mPhase   = M_OVER;
      mElapsed = 0;
      return;
    end
    case (mPhase)
      M_IDLE, M_OVER: begin
        if (start) begin
          mPhase   = M_FALL;
          mElapsed = 0;
          mResets  = 0;
        end
      end
      M_FALL: begin
        if (landed) begin
          mPhase   = M_LOCK;
          mElapsed = 0;
        end else if (mElapsed + 1 >= modelInterval()) begin
          mDrop    = 1'b1;
          mElapsed = 0;
        end else begin
          mElapsed++;
        end
      end
      M_LOCK: begin
        if (!landed) begin
          mPhase   = M_FALL;
          mElapsed = 0;
        end else if (moved && mResets < MAXR) begin
          mElapsed = 0;
          mResets++;
        end else if (mElapsed + 1 >= LOCKT) begin
          mLock    = 1'b1;
          mPhase   = M_CLEAR;
          mElapsed = 0;
          mResets  = 0;
        end else begin
          mElapsed++;
        end
      end
      M_CLEAR: begin
        if (clear_done) begin
          mPhase   = M_FALL;
          mElapsed = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Compare every output against the model.
  task automatic checkOutput();
    bit expPaused;
    expPaused = pause && modelInPlay();
    vectors++;
    assert (drop === mDrop) else begin
      miscompares++;
      $error("[TB] FAIL drop: observed %0b expected %0b at %0t", drop, mDrop, $time);
    end
    assert (lock === mLock) else begin
      miscompares++;
      $error("[TB] FAIL lock: observed %0b expected %0b at %0t", lock, mLock, $time);
    end
    assert (phase === 3'(mPhase)) else begin
      miscompares++;
      $error("[TB] FAIL phase: observed %0d expected %0d at %0t", phase, mPhase, $time);
    end
    assert (paused === expPaused) else begin
      miscompares++;
      $error("[TB] FAIL paused: observed %0b expected %0b at %0t", paused, expPaused, $time);
    end
  endtask

  // One clock: update the model, let the edge happen, then check just after it.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Clock until drop (or lock) shows up; n is the number of edges taken, -1 if the budget ran out.
  task automatic waitPulse(input bit wantLock, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      applyStimulus();
      if ((wantLock ? lock : drop) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    // Level 0 drops every 100 cycles, level 15 every 10.
    start = 1'b1; applyStimulus(); start = 1'b0;
    checkValue("enter_fall", int'(phase), M_FALL);
    waitPulse(1'b0, 150, n); checkValue("first_drop_lvl0", n, 100);
    waitPulse(1'b0, 150, n); checkValue("period_lvl0", n, 100);
    level = 4'd15;
    waitPulse(1'b0, 50, n);  checkValue("first_drop_lvl15", n, 10);
    waitPulse(1'b0, 50, n);  checkValue("period_lvl15", n, 10);

    // Soft drop 40 cycles into a 100-cycle interval fires at once, then every 5.
    level = 4'd0;
    waitPulse(1'b0, 150, n); checkValue("period_back_lvl0", n, 100);
    repeat (40) applyStimulus();
    soft_drop = 1'b1;
    waitPulse(1'b0, 10, n);  checkValue("soft_immediate", n, 1);
    waitPulse(1'b0, 10, n);  checkValue("soft_period", n, 5);
    soft_drop = 1'b0;
    waitPulse(1'b0, 150, n); checkValue("soft_release_period", n, 100);

    // Landing opens a 20-cycle lock window, then the clear phase.
    landed = 1'b1; applyStimulus();
    checkValue("enter_lock", int'(phase), M_LOCK);
    waitPulse(1'b1, 40, n);  checkValue("lock_delay", n, 20);
    checkValue("phase_after_lock", int'(phase), M_CLEAR);
    landed = 1'b0; clear_done = 1'b1; applyStimulus(); clear_done = 1'b0;
    checkValue("clear_to_fall", int'(phase), M_FALL);

    // Three moves at count 10: two restarts, the third ignored; 11 edges already spent since the second.
    landed = 1'b1; applyStimulus();
    for (int k = 0; k < 3; k++) begin
      repeat (10) applyStimulus();
      moved = 1'b1; applyStimulus(); moved = 1'b0;
    end
    waitPulse(1'b1, 40, n);  checkValue("lock_after_moves", n, 9);
    landed = 1'b0; clear_done = 1'b1; applyStimulus(); clear_done = 1'b0;

    // Pause at count 30 for 500 cycles; the drop lands 70 cycles after release.
    repeat (30) applyStimulus();
    pause = 1'b1;
    repeat (500) applyStimulus();
    checkValue("paused_flag", int'(paused), 1);
    pause = 1'b0;
    waitPulse(1'b0, 150, n); checkValue("resume_drop", n, 70);

    // clear_done with top_out ends the game.
    landed = 1'b1; applyStimulus();
    waitPulse(1'b1, 40, n);  checkValue("lock_before_topout", n, 20);
    landed = 1'b0; clear_done = 1'b1; top_out = 1'b1; applyStimulus();
    clear_done = 1'b0; top_out = 1'b0;
    checkValue("clear_topout_over", int'(phase), M_OVER);

    // Reset in the middle of a lock window, then a fresh start.
    start = 1'b1; applyStimulus(); start = 1'b0;
    landed = 1'b1; applyStimulus();
    repeat (5) applyStimulus();
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput();
    landed = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b1; applyStimulus(); start = 1'b0;
    waitPulse(1'b0, 150, n); checkValue("drop_after_restart", n, 100);

    // Random traffic with sticky level inputs and occasional pulses, checked every cycle.
    for (int c = 0; c < 4000; c++) begin
      start      = ($urandom_range(0, 49) == 0);
      moved      = ($urandom_range(0, 7) == 0);
      clear_done = ($urandom_range(0, 9) == 0);
      top_out    = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      if ($urandom_range(0, 59) == 0) soft_drop = ~soft_drop;
      if ($urandom_range(0, 79) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) landed = ~landed;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        #2;
        modelReset();
        checkOutput();
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        applyStimulus();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
